// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between a read-only fetch
// requester and a read/write data requester.
//   clk, rst                 : clock, asynchronous active-low reset
//   imem_req/addr            : fetch read request (level) and address
//   imem_data_out/ready      : fetch read data (registered) and completion pulse
//   dmem_re/wr/addr/data_in  : data read/write request, address, write value
//   dmem_data_out/ready      : data read data (registered) and completion pulse
//   mem_addr/data_in         : memory address and write data
//   data_out, mem_ready      : memory read data and completion
//   omem_re/omem_wr          : memory read/write strobes
//   err                      : sticky watchdog timeout flag
module mem_port_arbiter #(
  parameter int unsigned MAX_DMEM_STREAK = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data_out,
  output logic        imem_ready,
  input  logic        dmem_re,
  input  logic        dmem_wr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        dmem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  output logic        omem_re,
  output logic        omem_wr,
  input  logic        mem_ready,
  output logic        err
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;

  state_t          r_state, w_nxt_state;
  logic [SW-1:0]   r_streak, w_nxt_streak;
  logic [WW-1:0]   r_wd, w_nxt_wd;
  logic [DW-1:0]   r_mem_addr, w_nxt_mem_addr;
  logic [DW-1:0]   r_data_in, w_nxt_data_in;
  logic            r_re, w_nxt_re;
  logic            r_wr, w_nxt_wr;
  logic [DW-1:0]   r_imem_data, w_nxt_imem_data;
  logic [DW-1:0]   r_dmem_data, w_nxt_dmem_data;
  logic            r_imem_rdy, w_nxt_imem_rdy;
  logic            r_dmem_rdy, w_nxt_dmem_rdy;
  logic            r_err, w_nxt_err;

  logic            w_d_req;
  logic            w_fetch_forced;
  logic            w_timeout;

  assign w_d_req        = dmem_re | dmem_wr;
  // Fetch wins once data has taken MAX_DMEM_STREAK grants in a row while fetch waited.
  assign w_fetch_forced = imem_req && (r_streak == SW'(MAX_DMEM_STREAK));
  // Last allowed access cycle; TIMEOUT of zero never fires.
  assign w_timeout      = (TIMEOUT != 0) && (r_wd == WW'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_streak    = r_streak;
    w_nxt_wd        = '0;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_data_in   = r_data_in;
    w_nxt_re        = r_re;
    w_nxt_wr        = r_wr;
    w_nxt_imem_data = r_imem_data;
    w_nxt_dmem_data = r_dmem_data;
    w_nxt_imem_rdy  = 1'b0;
    w_nxt_dmem_rdy  = 1'b0;
    w_nxt_err       = r_err;

    case (r_state)
      IDLE: begin
        if (w_d_req && !w_fetch_forced) begin
          w_nxt_state    = D_ACC;
          w_nxt_mem_addr = dmem_addr;
          w_nxt_wr       = dmem_wr;
          w_nxt_re       = !dmem_wr;
          w_nxt_data_in  = dmem_wr ? dmem_data_in : '0;
          if (!imem_req)
            w_nxt_streak = '0;
          else if (r_streak != SW'(MAX_DMEM_STREAK))
            w_nxt_streak = r_streak + SW'(1);
        end else if (imem_req) begin
          w_nxt_state    = I_ACC;
          w_nxt_mem_addr = imem_addr;
          w_nxt_re       = 1'b1;
          w_nxt_wr       = 1'b0;
          w_nxt_data_in  = '0;
          w_nxt_streak   = '0;
        end
      end
      I_ACC, D_ACC: begin
        if (mem_ready) begin
          w_nxt_re    = 1'b0;
          w_nxt_wr    = 1'b0;
          w_nxt_state = RESP;
          if (r_state == I_ACC) begin
            w_nxt_imem_data = data_out;
            w_nxt_imem_rdy  = 1'b1;
          end else begin
            if (r_re) w_nxt_dmem_data = data_out;
            w_nxt_dmem_rdy = 1'b1;
          end
        end else if (w_timeout) begin
          // Abort: complete the owner with zero data and flag the error.
          w_nxt_re    = 1'b0;
          w_nxt_wr    = 1'b0;
          w_nxt_err   = 1'b1;
          w_nxt_state = RESP;
          if (r_state == I_ACC) begin
            w_nxt_imem_data = '0;
            w_nxt_imem_rdy  = 1'b1;
          end else begin
            w_nxt_dmem_data = '0;
            w_nxt_dmem_rdy  = 1'b1;
          end
        end else begin
          w_nxt_wd = r_wd + WW'(1);
        end
      end
      RESP:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_wd        <= '0;
      r_mem_addr  <= '0;
      r_data_in   <= '0;
      r_re        <= 1'b0;
      r_wr        <= 1'b0;
      r_imem_data <= '0;
      r_dmem_data <= '0;
      r_imem_rdy  <= 1'b0;
      r_dmem_rdy  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_streak    <= w_nxt_streak;
      r_wd        <= w_nxt_wd;
      r_mem_addr  <= w_nxt_mem_addr;
      r_data_in   <= w_nxt_data_in;
      r_re        <= w_nxt_re;
      r_wr        <= w_nxt_wr;
      r_imem_data <= w_nxt_imem_data;
      r_dmem_data <= w_nxt_dmem_data;
      r_imem_rdy  <= w_nxt_imem_rdy;
      r_dmem_rdy  <= w_nxt_dmem_rdy;
      r_err       <= w_nxt_err;
    end
  end

  assign imem_data_out = r_imem_data;
  assign imem_ready    = r_imem_rdy;
  assign dmem_data_out = r_dmem_data;
  assign dmem_ready    = r_dmem_rdy;
  assign mem_addr      = r_mem_addr;
  assign data_in       = r_data_in;
  assign omem_re       = r_re;
  assign omem_wr       = r_wr;
  assign err           = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TMO  = 8;

  logic        clk, rst;
  logic        imem_req, dmem_re, dmem_wr, mem_ready;
  logic [31:0] imem_addr, dmem_addr, dmem_data_in, data_out;
  logic [31:0] imem_data_out, dmem_data_out, mem_addr, data_in;
  logic        imem_ready, dmem_ready, omem_re, omem_wr, err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MAX_DMEM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data_out(imem_data_out), .imem_ready(imem_ready),
    .dmem_re(dmem_re), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
    .dmem_ready(dmem_ready),
    .mem_addr(mem_addr), .data_in(data_in), .data_out(data_out),
    .omem_re(omem_re), .omem_wr(omem_wr), .mem_ready(mem_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n begins 1 time unit after posedge n: outputs settled, inputs for edge n+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req = 0; dmem_re = 0; dmem_wr = 0; mem_ready = 0;
    imem_addr = '0; dmem_addr = '0; dmem_data_in = '0; data_out = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    step();
    total++;
    if ({omem_re, omem_wr, mem_addr, data_in, imem_ready, dmem_ready, err, imem_data_out, dmem_data_out} !== '0) begin
      bad++; $display("FAIL reset_outputs got re=%b wr=%b addr=%h din=%h irdy=%b drdy=%b err=%b idat=%h ddat=%h exp all zero",
                      omem_re, omem_wr, mem_addr, data_in, imem_ready, dmem_ready, err, imem_data_out, dmem_data_out);
    end
    rst = 1;
    step();
  endtask

  task automatic test_fetch();
    do_reset();
    imem_req = 1; imem_addr = 32'h100;
    step(); // cycle 1
    total++; if ({omem_re, omem_wr, mem_addr} !== {2'b10, 32'h100}) begin bad++; $display("FAIL fetch_c1 got re=%b wr=%b addr=%h exp re=1 wr=0 addr=100", omem_re, omem_wr, mem_addr); end
    step(); // cycle 2
    total++; if ({omem_re, mem_addr} !== {1'b1, 32'h100}) begin bad++; $display("FAIL fetch_c2 got re=%b addr=%h exp re=1 addr=100", omem_re, mem_addr); end
    mem_ready = 1; data_out = 32'hDEADBEEF;
    step(); // cycle 3
    total++; if ({imem_ready, dmem_ready, omem_re, err} !== 4'b1000) begin bad++; $display("FAIL fetch_c3_ctl got irdy=%b drdy=%b re=%b err=%b exp 1 0 0 0", imem_ready, dmem_ready, omem_re, err); end
    total++; if (imem_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_data got=%h exp=deadbeef", imem_data_out); end
    imem_req = 0; mem_ready = 0;
    step(); // cycle 4
    total++; if ({imem_ready, omem_re} !== 2'b00) begin bad++; $display("FAIL fetch_c4 got irdy=%b re=%b exp 0 0", imem_ready, omem_re); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    imem_req = 1; imem_addr = 32'h200;
    dmem_wr = 1; dmem_addr = 32'h40; dmem_data_in = 32'h55;
    step();
    total++; if ({omem_re, omem_wr, mem_addr, data_in} !== {2'b01, 32'h40, 32'h55}) begin bad++; $display("FAIL simul_dwrite got re=%b wr=%b addr=%h din=%h exp 0 1 40 55", omem_re, omem_wr, mem_addr, data_in); end
    mem_ready = 1; data_out = 32'hABCD0000;
    step();
    total++; if ({dmem_ready, imem_ready, omem_wr} !== 3'b100) begin bad++; $display("FAIL simul_dready got drdy=%b irdy=%b wr=%b exp 1 0 0", dmem_ready, imem_ready, omem_wr); end
    total++; if (dmem_data_out !== 32'h0) begin bad++; $display("FAIL simul_wdata_kept got=%h exp=0", dmem_data_out); end
    dmem_wr = 0; mem_ready = 0;
    step(); // IDLE, fetch sampled at the next edge
    step();
    total++; if ({omem_re, omem_wr, mem_addr} !== {2'b10, 32'h200}) begin bad++; $display("FAIL simul_fetch got re=%b wr=%b addr=%h exp 1 0 200", omem_re, omem_wr, mem_addr); end
    mem_ready = 1; data_out = 32'h1234;
    step();
    total++; if ({imem_ready, imem_data_out} !== {1'b1, 32'h1234}) begin bad++; $display("FAIL simul_iready got irdy=%b data=%h exp 1 1234", imem_ready, imem_data_out); end
    idle_inputs();
    step();
  endtask

  task automatic test_starvation();
    logic [5:0] grants;
    int ngr, dcnt, icnt, ipos;
    grants = '0; ngr = 0; dcnt = 0; icnt = 0; ipos = -1;
    do_reset();
    imem_req = 1; imem_addr = 32'h1000;
    dmem_re = 1; dmem_addr = 32'h2000;
    mem_ready = 1; data_out = 32'h11;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (omem_re) begin grants = {grants[4:0], (mem_addr == 32'h1000)}; ngr++; end
      if (dmem_ready) dcnt++;
      if (imem_ready) begin icnt++; ipos = dcnt; end
    end
    total++; if ({ngr, grants} !== {32'd6, 6'b000010}) begin bad++; $display("FAIL starve_order got n=%0d seq=%b exp n=6 seq=000010", ngr, grants); end
    total++; if ({icnt, ipos} !== {32'd1, 32'd4}) begin bad++; $display("FAIL starve_iready got count=%0d after_d=%0d exp 1 after 4", icnt, ipos); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    dmem_re = 1; dmem_addr = 32'h300;
    step();
    mem_ready = 1; data_out = 32'hA5A5A5A5;
    step();
    total++; if ({dmem_ready, dmem_data_out} !== {1'b1, 32'hA5A5A5A5}) begin bad++; $display("FAIL tmo_preread got drdy=%b data=%h exp 1 a5a5a5a5", dmem_ready, dmem_data_out); end
    dmem_re = 0; mem_ready = 0;
    step();
    dmem_re = 1; dmem_addr = 32'h304;
    step();
    hi = 0;
    for (int c = 1; c <= int'(TMO); c++) begin
      if (omem_re) hi++;
      step();
    end
    total++; if (hi !== int'(TMO)) begin bad++; $display("FAIL tmo_strobe_len got=%0d exp=%0d", hi, TMO); end
    total++; if ({omem_re, dmem_ready, err, dmem_data_out} !== {3'b011, 32'h0}) begin bad++; $display("FAIL tmo_abort got re=%b drdy=%b err=%b data=%h exp 0 1 1 0", omem_re, dmem_ready, err, dmem_data_out); end
    dmem_re = 0;
    step();
    imem_req = 1; imem_addr = 32'h700;
    step();
    mem_ready = 1; data_out = 32'h99;
    step();
    total++; if ({imem_ready, imem_data_out, err} !== {1'b1, 32'h99, 1'b1}) begin bad++; $display("FAIL tmo_sticky got irdy=%b data=%h err=%b exp 1 99 1", imem_ready, imem_data_out, err); end
    idle_inputs();
    step();
    rst = 0;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_clear got=%b exp=0", err); end
    step();
    rst = 1;
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    dmem_re = 1; dmem_addr = 32'h400;
    step();
    for (int c = 1; c < int'(TMO); c++) step();
    mem_ready = 1; data_out = 32'h77;
    step();
    total++; if ({dmem_ready, dmem_data_out, err} !== {1'b1, 32'h77, 1'b0}) begin bad++; $display("FAIL tmo_tie got drdy=%b data=%h err=%b exp 1 77 0", dmem_ready, dmem_data_out, err); end
    idle_inputs();
    step();
  endtask

  task automatic test_illegal();
    int noise;
    do_reset();
    dmem_re = 1; dmem_wr = 1; dmem_addr = 32'h80; dmem_data_in = 32'h99;
    step();
    total++; if ({omem_re, omem_wr, mem_addr, data_in} !== {2'b01, 32'h80, 32'h99}) begin bad++; $display("FAIL ill_rewr got re=%b wr=%b addr=%h din=%h exp 0 1 80 99", omem_re, omem_wr, mem_addr, data_in); end
    dmem_addr = 32'hFFFF0000; dmem_re = 0; dmem_data_in = 32'h1;
    step();
    total++; if ({omem_wr, mem_addr, data_in} !== {1'b1, 32'h80, 32'h99}) begin bad++; $display("FAIL ill_hold got wr=%b addr=%h din=%h exp 1 80 99", omem_wr, mem_addr, data_in); end
    mem_ready = 1;
    step();
    total++; if (dmem_ready !== 1'b1) begin bad++; $display("FAIL ill_wdone got=%b exp=1", dmem_ready); end
    dmem_wr = 0;
    step();
    noise = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = c[0];
      step();
      if (imem_ready | dmem_ready | omem_re | omem_wr) noise++;
    end
    total++; if (noise !== 0) begin bad++; $display("FAIL ill_idle_ready got=%0d active cycles exp=0", noise); end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_access();
    int pulses;
    do_reset();
    imem_req = 1; imem_addr = 32'h500;
    step();
    total++; if (omem_re !== 1'b1) begin bad++; $display("FAIL rma_pre got=%b exp=1", omem_re); end
    #2 rst = 0;
    #1;
    total++; if ({omem_re, mem_addr} !== {1'b0, 32'h0}) begin bad++; $display("FAIL rma_async got re=%b addr=%h exp 0 0", omem_re, mem_addr); end
    pulses = 0;
    mem_ready = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      if (imem_ready) pulses++;
    end
    mem_ready = 0;
    rst = 1;
    step();
    if (imem_ready) pulses++;
    total++; if (pulses !== 0) begin bad++; $display("FAIL rma_no_ready got=%0d exp=0", pulses); end
    total++; if ({omem_re, mem_addr} !== {1'b1, 32'h500}) begin bad++; $display("FAIL rma_restart got re=%b addr=%h exp 1 500", omem_re, mem_addr); end
    mem_ready = 1; data_out = 32'h5A;
    step();
    total++; if ({imem_ready, imem_data_out} !== {1'b1, 32'h5A}) begin bad++; $display("FAIL rma_done got irdy=%b data=%h exp 1 5a", imem_ready, imem_data_out); end
    idle_inputs();
    step();
  endtask

  // Transaction-level model: priority rule with an integer streak count,
  // random memory latency, timeouts when latency exceeds TMO.
  task automatic test_random();
    int unsigned m_streak;
    logic        m_err;
    logic [31:0] m_idata, m_ddata;
    logic        ir, dr, dw, dwin, iwin, e_re, e_wr, hit, tmo;
    logic [31:0] ia, da, dd, e_addr, e_din, rdata;
    int          lat;
    do_reset();
    m_streak = 0; m_err = 0; m_idata = '0; m_ddata = '0;
    for (int t = 0; t < 200; t++) begin
      ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); dw = 1'($urandom_range(0, 1));
      ia = $urandom; da = $urandom; dd = $urandom;
      imem_req = ir; imem_addr = ia; dmem_re = dr; dmem_wr = dw;
      dmem_addr = da; dmem_data_in = dd;
      mem_ready = 1'($urandom_range(0, 1)); data_out = $urandom;
      dwin = (dr | dw) && !(ir && m_streak == MAXS);
      iwin = !dwin && ir;
      step();
      mem_ready = 0;
      if (!dwin && !iwin) begin
        total++; if ({omem_re, omem_wr, imem_ready, dmem_ready} !== 4'b0) begin bad++; $display("FAIL rnd_idle t=%0d got re=%b wr=%b irdy=%b drdy=%b exp 0", t, omem_re, omem_wr, imem_ready, dmem_ready); end
        continue;
      end
      if (dwin) m_streak = ir ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      else      m_streak = 0;
      e_wr = dwin && dw;
      e_re = !e_wr;
      e_addr = dwin ? da : ia;
      e_din = e_wr ? dd : 32'h0;
      lat = int'($urandom_range(1, 10));
      tmo = (lat > int'(TMO));
      rdata = $urandom;
      hit = 0;
      for (int c = 1; c <= int'(TMO) && !hit; c++) begin
        total++; if ({omem_re, omem_wr, mem_addr, data_in} !== {e_re, e_wr, e_addr, e_din}) begin
          bad++; $display("FAIL rnd_access t=%0d c=%0d got re=%b wr=%b addr=%h din=%h exp %b %b %h %h", t, c, omem_re, omem_wr, mem_addr, data_in, e_re, e_wr, e_addr, e_din);
        end
        imem_req = 1'($urandom_range(0, 1)); dmem_re = 1'($urandom_range(0, 1)); dmem_wr = 1'($urandom_range(0, 1));
        imem_addr = $urandom; dmem_addr = $urandom; dmem_data_in = $urandom;
        if (c == lat) begin mem_ready = 1; data_out = rdata; hit = 1; end
        else begin mem_ready = 0; data_out = $urandom; end
        step();
      end
      if (iwin) m_idata = tmo ? 32'h0 : rdata;
      else if (tmo) m_ddata = 32'h0;
      else if (!e_wr) m_ddata = rdata;
      if (tmo) m_err = 1;
      total++; if ({imem_ready, dmem_ready, omem_re, omem_wr, err} !== {iwin, dwin, 2'b00, m_err}) begin
        bad++; $display("FAIL rnd_resp t=%0d got irdy=%b drdy=%b re=%b wr=%b err=%b exp %b %b 0 0 %b", t, imem_ready, dmem_ready, omem_re, omem_wr, err, iwin, dwin, m_err);
      end
      total++; if ({imem_data_out, dmem_data_out} !== {m_idata, m_ddata}) begin
        bad++; $display("FAIL rnd_data t=%0d got i=%h d=%h exp i=%h d=%h", t, imem_data_out, dmem_data_out, m_idata, m_ddata);
      end
      imem_req = 0; dmem_re = 0; dmem_wr = 0;
      mem_ready = 1'($urandom_range(0, 1));
      step();
      total++; if ({imem_ready, dmem_ready, omem_re, omem_wr} !== 4'b0) begin bad++; $display("FAIL rnd_pulse_end t=%0d got irdy=%b drdy=%b re=%b wr=%b exp 0", t, imem_ready, dmem_ready, omem_re, omem_wr); end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_timeout_boundary();
    test_illegal();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit exceeded");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the fetch requester (read-only) and the data requester (read/write).
- Serialises accesses with a 4-state FSM.
- Gives data accesses priority, with an anti-starvation streak limit for fetch.
- Captures returned read data into per-requester registers and signals completion with a one-cycle ready pulse.
- Adds a watchdog that aborts accesses when memory never answers.

Parameters:
- MAX_DMEM_STREAK, 4: consecutive data grants allowed while fetch is waiting before fetch is forced to win (1..15).
- TIMEOUT, 255: cycles in an access state without mem_ready before abort; 0 disables the watchdog (0..255).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- imem_req  input  1  fetch read request, level, held until imem_ready
- imem_addr  input  32  fetch address
- imem_data_out  output  32  fetch read data, registered
- imem_ready  output  1  fetch completion pulse
- dmem_re  input  1  data read request, level
- dmem_wr  input  1  data write request, level
- dmem_addr  input  32  data address
- dmem_data_in  input  32  data write value
- dmem_data_out  output  32  data read data, registered
- dmem_ready  output  1  data completion pulse
- mem_addr  output  32  memory address
- data_in  output  32  memory write data
- data_out  input  32  memory read data
- omem_re  output  1  memory read strobe
- omem_wr  output  1  memory write strobe
- mem_ready  input  1  memory completion
- err  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including both *_data_out, both ready signals, err, streak counter and watchdog.
- All outputs are registered.
- FSM states: IDLE, I_ACC, D_ACC, RESP.
- IDLE, arbitration:
  - d_req = dmem_re | dmem_wr.
  - If d_req and not (imem_req and streak==MAX_DMEM_STREAK): go to D_ACC.
  - Else if imem_req: go to I_ACC.
  - Else stay in IDLE.
- IDLE, on transition: latch mem_addr, data_in (dmem_data_in on write, else 0), omem_re/omem_wr. Strobes rise the cycle after the request is sampled.
- dmem_re and dmem_wr both high: treated as a write (omem_wr=1, omem_re=0).
- Streak counter, updated on a D_ACC grant:
  - increments if imem_req was high at that grant, saturating at MAX_DMEM_STREAK;
  - clears if imem_req was low;
  - clears on every I_ACC grant.
- I_ACC / D_ACC:
  - Strobes, address and data are held constant; request-input changes are ignored.
  - On mem_ready=1:
    - drop strobes;
    - on a read, capture data_out into the owner's *_data_out (writes leave dmem_data_out unchanged);
    - pulse the owner's ready to 1 next cycle;
    - go to RESP.
  - The watchdog counts cycles in the state. If TIMEOUT!=0 and the count reaches TIMEOUT without mem_ready:
    - drop strobes;
    - set err=1 (sticky until reset);
    - pulse the owner's ready with *_data_out=0;
    - go to RESP.
  - mem_ready and timeout in the same cycle: mem_ready wins, err unchanged.
- RESP:
  - Ready is high for exactly this cycle; requests are not sampled; next state IDLE.
  - The requester must drop its request (or present the next one) on the cycle ready is high.
- Latency: request sampled at cycle 0, strobe at 1, mem_ready at k≥1, ready pulse at k+1, next arbitration at k+2. With mem_ready at cycle 1, that is 3-cycle minimum per access.
- mem_ready in IDLE or RESP is ignored.
- Reset mid-access drops strobes immediately and discards the access; no ready pulse.

Test Plan:
- Fetch only: imem_req=1, imem_addr=0x100, mem_ready on strobe cycle 2 with data_out=0xDEADBEEF -> omem_re=1 with mem_addr=0x100 in cycles 1-2; imem_ready=1 in cycle 3 with imem_data_out=0xDEADBEEF; omem_re=0 from cycle 3; err=0.
- Simultaneous requests, imem_req=1 and dmem_wr=1 at addr 0x40, data 0x55: data write first (omem_wr=1, data_in=0x55, mem_addr=0x40, dmem_ready pulse); then fetch granted in the next IDLE.
- Starvation, MAX_DMEM_STREAK=4, dmem_re and imem_req held high, mem_ready=1 in each access state: grant order D,D,D,D,I,D...; imem_ready exactly once after the 4th dmem_ready.
- Timeout, TIMEOUT=8, dmem_re=1, mem_ready held 0: strobe drops after 8 access cycles; dmem_ready pulse with dmem_data_out=0; err=1 and stays 1 through later successful accesses until rst=0.
- Illegal/ignored inputs:
  - dmem_re=dmem_wr=1 -> only omem_wr asserted.
  - dmem_addr changed mid-access -> mem_addr unchanged.
  - mem_ready pulsed in IDLE -> no ready pulses.
- Reset mid-access: assert rst=0 during I_ACC -> omem_re=0 immediately (asynchronous), imem_ready never pulses. After release, imem_req still high -> new access from cycle 1.
